// File: rtl/fp32_pkg.sv
// FP32 field helpers and constants shared by the dot-product PE and its adder.
// Subnormals are treated as zero everywhere (flush-to-zero arithmetic).
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [31:0] FP_POS_INF = 32'h7F800000;

    function automatic logic fp_sign(input logic [31:0] v);
        return v[31];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] v);
        return v[30:23];
    endfunction

    function automatic logic [MAN_W-1:0] fp_man(input logic [31:0] v);
        return v[22:0];
    endfunction

    function automatic logic is_nan(input logic [31:0] v);
        return (fp_exp(v) == 8'hFF) && (fp_man(v) != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        return (fp_exp(v) == 8'hFF) && (fp_man(v) == 23'd0);
    endfunction

    // A zero exponent field is zero or subnormal; both behave as signed zero.
    function automatic logic is_zero(input logic [31:0] v);
        return fp_exp(v) == 8'd0;
    endfunction

endpackage

// File: rtl/fp32_add.sv
// Combinational FP32 adder: align, add/subtract, normalize, round-to-nearest-even,
// flush-to-zero, and IEEE special-value handling with a canonical quiet NaN.
module fp32_add
    import fp32_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] sum
);

    // m holds a normalized significand with bit 26 as the hidden one, then
    // guard, round and sticky bits; e is the unbiased-range biased exponent.
    function automatic logic [31:0] round_pack(input logic sgn,
                                               input logic signed [9:0] e,
                                               input logic [26:0] m);
        logic              inc;
        logic [24:0]       r;
        logic signed [9:0] e2;
        logic [22:0]       frac;
        inc = m[2] & (m[1] | m[0] | m[3]);
        r   = {1'b0, m[26:3]} + {24'd0, inc};
        if (r[24]) begin
            e2   = e + 10'sd1;
            frac = 23'd0;
        end else begin
            e2   = e;
            frac = r[22:0];
        end
        if (e2 >= 10'sd255)
            return {sgn, 8'hFF, 23'd0};
        else if (e2 <= 10'sd0)
            return {sgn, 31'd0};
        else
            return {sgn, e2[7:0], frac};
    endfunction

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n     = n + 5'd1;
            end
        end
        return n;
    endfunction

    logic [31:0]       big;
    logic [30:0]       sml;
    logic [7:0]        d;
    logic [53:0]       ext;
    logic [26:0]       bm;
    logic [26:0]       sm;
    logic [27:0]       s28;
    logic [26:0]       diff;
    logic [4:0]        lz;
    logic [26:0]       m_norm;
    logic signed [9:0] e_norm;
    logic [31:0]       norm_res;

    // Finite nonzero path: the larger magnitude keeps its sign, so a
    // subtraction never goes negative and needs no re-complement.
    always_comb begin
        big    = (y[30:0] > x[30:0]) ? y : x;
        sml    = (y[30:0] > x[30:0]) ? x[30:0] : y[30:0];
        d      = big[30:23] - sml[30:23];
        bm     = {1'b1, big[22:0], 3'b000};
        ext    = {1'b1, sml[22:0], 30'd0} >> d;
        // Beyond 26 places the smaller operand only contributes to sticky.
        sm     = (d > 8'd26) ? 27'd1 : {ext[53:28], ext[27] | (|ext[26:0])};
        s28    = {1'b0, bm} + {1'b0, sm};
        diff   = bm - sm;
        lz     = lzc27(diff);
        m_norm = bm;
        e_norm = $signed({2'b00, big[30:23]});
        if (x[31] == y[31]) begin
            if (s28[27]) begin
                m_norm = {s28[27:2], s28[1] | s28[0]};
                e_norm = $signed({2'b00, big[30:23]}) + 10'sd1;
            end else begin
                m_norm = s28[26:0];
            end
            norm_res = round_pack(big[31], e_norm, m_norm);
        end else if (diff == 27'd0) begin
            norm_res = 32'h0000_0000;
        end else begin
            m_norm   = diff << lz;
            e_norm   = $signed({2'b00, big[30:23]}) - $signed({5'd0, lz});
            norm_res = round_pack(big[31], e_norm, m_norm);
        end
    end

    // Special operands override the arithmetic path.
    always_comb begin
        if (is_nan(x) || is_nan(y))
            sum = FP_QNAN;
        else if (is_inf(x) && is_inf(y))
            sum = (x[31] != y[31]) ? FP_QNAN : x;
        else if (is_inf(x))
            sum = x;
        else if (is_inf(y))
            sum = y;
        else if (is_zero(x) && is_zero(y))
            sum = {x[31] & y[31], 31'd0};
        else if (is_zero(x))
            sum = y;
        else if (is_zero(y))
            sum = x;
        else
            sum = norm_res;
    end

endmodule

// File: rtl/pe_no_fifo.sv
// FP32 dot-product processing element for a matrix-multiplier array.
// Three register stages: multiply, accumulate, result hold. One pair per cycle.
module pe_no_fifo
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        valid_in,
    input  logic        last,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c,
    output logic        output_valid
);

    // Same significand layout as the adder: bit 26 hidden one, then G/R/S.
    function automatic logic [31:0] round_pack(input logic sgn,
                                               input logic signed [9:0] e,
                                               input logic [26:0] m);
        logic              inc;
        logic [24:0]       r;
        logic signed [9:0] e2;
        logic [22:0]       frac;
        inc = m[2] & (m[1] | m[0] | m[3]);
        r   = {1'b0, m[26:3]} + {24'd0, inc};
        if (r[24]) begin
            e2   = e + 10'sd1;
            frac = 23'd0;
        end else begin
            e2   = e;
            frac = r[22:0];
        end
        if (e2 >= 10'sd255)
            return {sgn, 8'hFF, 23'd0};
        else if (e2 <= 10'sd0)
            return {sgn, 31'd0};
        else
            return {sgn, e2[7:0], frac};
    endfunction

    logic              psign_p0;
    logic [47:0]       mprod_p0;
    logic signed [9:0] mexp_p0;
    logic [26:0]       mman_p0;
    logic [31:0]       prod_p0;

    logic [31:0]       prod_p1;
    logic              vld_p1;
    logic              start_p1;
    logic              last_p1;
    logic [31:0]       sum_p1;

    logic [31:0]       acc_p2;
    logic              fin_p2;

    // FP32 multiply: 24x24 significand product, exponent add, round, specials.
    always_comb begin
        psign_p0 = a[31] ^ b[31];
        mprod_p0 = {24'd0, 1'b1, fp_man(a)} * {24'd0, 1'b1, fp_man(b)};
        mexp_p0  = $signed({2'b00, fp_exp(a)}) + $signed({2'b00, fp_exp(b)}) - 10'sd127;
        if (mprod_p0[47]) begin
            mman_p0 = {mprod_p0[47:22], |mprod_p0[21:0]};
            mexp_p0 = mexp_p0 + 10'sd1;
        end else begin
            mman_p0 = {mprod_p0[46:21], |mprod_p0[20:0]};
        end
        if (is_nan(a) || is_nan(b))
            prod_p0 = FP_QNAN;
        else if (is_inf(a) || is_inf(b))
            prod_p0 = (is_zero(a) || is_zero(b)) ? FP_QNAN : {psign_p0, 8'hFF, 23'd0};
        else if (is_zero(a) || is_zero(b))
            prod_p0 = {psign_p0, 31'd0};
        else
            prod_p0 = round_pack(psign_p0, mexp_p0, mman_p0);
    end

    fp32_add u_add (
        .x   (acc_p2),
        .y   (prod_p1),
        .sum (sum_p1)
    );

    // Stage 1: register the product with its qualified control bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p1  <= 32'd0;
            vld_p1   <= 1'b0;
            start_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            prod_p1  <= prod_p0;
            vld_p1   <= valid_in;
            start_p1 <= valid_in & start;
            last_p1  <= valid_in & last;
        end
    end

    // Stage 2: accumulate; a start term replaces the running sum outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p2 <= 32'd0;
            fin_p2 <= 1'b0;
        end else begin
            if (vld_p1)
                acc_p2 <= start_p1 ? prod_p1 : sum_p1;
            fin_p2 <= vld_p1 & last_p1;
        end
    end

    // Stage 3: publish a finished sum; a new start drops valid unless a result lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c            <= 32'd0;
            output_valid <= 1'b0;
        end else if (fin_p2) begin
            c            <= acc_p2;
            output_valid <= 1'b1;
        end else if (valid_in && start) begin
            output_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pe_no_fifo.sv
// Bench for the FP32 dot-product PE: directed vector table, hand-written
// multi-cycle sequences, and random stimulus against a real-number model.
module tb_pe_no_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        valid_in;
    logic        last;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        output_valid;

    always #5 clk = ~clk;

    pe_no_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .valid_in     (valid_in),
        .last         (last),
        .a            (a),
        .b            (b),
        .c            (c),
        .output_valid (output_valid)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          due;
        logic [31:0] res;
    } pend_t;

    typedef struct {
        string       name;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [31:0] exp_c;
    } vec_t;

    pend_t       pend[$];
    vec_t        tv[$];
    logic [31:0] m_acc;
    logic [31:0] m_c;
    logic        m_ov;
    int          edge_n;
    bit          in_vec;

    // ---------------- reference arithmetic ----------------
    function automatic bit r_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction
    function automatic bit r_inf(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
    endfunction
    function automatic bit r_zero(input logic [31:0] v);
        return v[30:23] == 8'd0;
    endfunction

    function automatic real f2r(input logic [31:0] v);
        logic [10:0] e11;
        e11 = {3'b000, v[30:23]} + 11'd896;
        return $bitstoreal({v[31], e11, v[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        logic [22:0] frac;
        logic        inc;
        logic [24:0] m;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'h0000_0000;
        e    = int'(d[62:52]) - 896;
        frac = d[51:29];
        inc  = d[28] & ((|d[27:0]) | d[29]);
        m    = {2'b01, frac} + {24'd0, inc};
        if (m[24]) begin
            e++;
            frac = 23'd0;
        end else begin
            frac = m[22:0];
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {d[63], 31'd0};
        return {d[63], e[7:0], frac};
    endfunction

    function automatic logic [31:0] m_mul(input logic [31:0] x, input logic [31:0] y);
        logic s;
        s = x[31] ^ y[31];
        if (r_nan(x) || r_nan(y)) return 32'h7FC00000;
        if (r_inf(x) || r_inf(y)) return (r_zero(x) || r_zero(y)) ? 32'h7FC00000 : {s, 8'hFF, 23'd0};
        if (r_zero(x) || r_zero(y)) return {s, 31'd0};
        return r2f(f2r(x) * f2r(y));
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
        if (r_nan(x) || r_nan(y)) return 32'h7FC00000;
        if (r_inf(x) && r_inf(y)) return (x[31] != y[31]) ? 32'h7FC00000 : x;
        if (r_inf(x)) return x;
        if (r_inf(y)) return y;
        if (r_zero(x) && r_zero(y)) return {x[31] & y[31], 31'd0};
        if (r_zero(x)) return y;
        if (r_zero(y)) return x;
        return r2f(f2r(x) + f2r(y));
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Observable behaviour of one rising edge given the inputs it samples.
    task automatic model_edge(input logic v, input logic s, input logic l,
                              input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] p;
        edge_n++;
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            m_c  = pend[0].res;
            m_ov = 1'b1;
            void'(pend.pop_front());
        end else if (v && s) begin
            m_ov = 1'b0;
        end
        if (v) begin
            p     = m_mul(av, bv);
            m_acc = s ? p : m_add(m_acc, p);
            if (l) pend.push_back('{edge_n + 2, m_acc});
        end
    endtask

    task automatic model_reset();
        m_acc = 32'd0;
        m_c   = 32'd0;
        m_ov  = 1'b0;
        pend.delete();
    endtask

    // Called at a falling edge; drives, clocks once, then compares at the next falling edge.
    task automatic step(input logic v, input logic s, input logic l,
                        input logic [31:0] av, input logic [31:0] bv);
        valid_in = v;
        start    = s;
        last     = l;
        a        = av;
        b        = bv;
        @(posedge clk);
        model_edge(v, s, l, av, bv);
        @(negedge clk);
        chk("cycle_c", c, m_c);
        chk("cycle_ov", {31'd0, output_valid}, {31'd0, m_ov});
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom);
    endtask

    task automatic add_vec(input string n, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] e);
        tv.push_back('{n, a0, b0, a1, b1, e});
    endtask

    function automatic logic [31:0] rnd_op();
        int unsigned k;
        logic        sg;
        k  = $urandom_range(0, 63);
        sg = 1'($urandom);
        case (k)
            0:       return {sg, 31'd0};
            1:       return {sg, 8'hFF, 23'd0};
            2:       return {sg, 8'hFF, 23'($urandom_range(1, 8388607))};
            3:       return {sg, 8'd0, 23'($urandom_range(1, 8388607))};
            default: return {sg, 8'($urandom_range(125, 129)), 23'($urandom)};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rv, rs, rl;
        rst_n    = 1'b1;
        start    = 1'b0;
        valid_in = 1'b0;
        last     = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        edge_n   = 0;
        in_vec   = 1'b0;
        model_reset();

        add_vec("plan_13",     32'h40600000, 32'h40000000, 32'h3FC00000, 32'h40800000, 32'h41500000);
        add_vec("plan_neg13",  32'hBFC00000, 32'h40800000, 32'h40000000, 32'hC0600000, 32'hC1500000);
        add_vec("zeros",       32'h00000000, 32'h40A00000, 32'h40000000, 32'h00000000, 32'h00000000);
        add_vec("inf_plus0",   32'h7F800000, 32'h40000000, 32'h00000000, 32'h3F800000, 32'h7F800000);
        add_vec("nan_prop",    32'h7FC00000, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000);
        add_vec("inf_times0",  32'h7F800000, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h7FC00000);
        add_vec("mul_ovf",     32'h7F000000, 32'h40000000, 32'h00000000, 32'h3F800000, 32'h7F800000);
        add_vec("subn_in",     32'h00400000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h00000000);
        add_vec("negzero_sum", 32'h80000000, 32'h3F800000, 32'h00000000, 32'hBF800000, 32'h80000000);
        add_vec("inf_m_inf",   32'h7F800000, 32'h3F800000, 32'hFF800000, 32'h3F800000, 32'h7FC00000);
        add_vec("cancel",      32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h00000000);
        add_vec("rne_tie",     32'h3F800000, 32'h3F800000, 32'h33800000, 32'h3F800000, 32'h3F800000);
        add_vec("rne_up",      32'h3F800000, 32'h3F800000, 32'h33C00000, 32'h3F800000, 32'h3F800001);
        add_vec("mul_unf",     32'h00800000, 32'h3F000000, 32'h00000000, 32'h00000000, 32'h00000000);

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        chk("reset_c", c, 32'd0);
        chk("reset_ov", {31'd0, output_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed two-term vectors with fixed expected results
        for (int i = 0; i < tv.size(); i++) begin
            step(1'b1, 1'b1, 1'b0, tv[i].a0, tv[i].b0);
            chk({tv[i].name, "_ov_cleared"}, {31'd0, output_valid}, 32'd0);
            step(1'b1, 1'b0, 1'b1, tv[i].a1, tv[i].b1);
            idle();
            chk({tv[i].name, "_ov_early"}, {31'd0, output_valid}, 32'd0);
            idle();
            chk({tv[i].name, "_c"}, c, tv[i].exp_c);
            chk({tv[i].name, "_ov"}, {31'd0, output_valid}, 32'd1);
            step(1'b0, 1'b1, 1'b1, 32'h3F800000, 32'h3F800000);
            chk({tv[i].name, "_c_hold"}, c, tv[i].exp_c);
        end

        // Back-to-back vectors including a single-term one
        step(1'b1, 1'b1, 1'b0, 32'h3F800000, 32'h3F800000);
        step(1'b1, 1'b0, 1'b1, 32'h40000000, 32'h40000000);
        step(1'b1, 1'b1, 1'b1, 32'h40000000, 32'h40000000);
        step(1'b1, 1'b1, 1'b0, 32'h40400000, 32'h3F800000);
        chk("b2b_first_c", c, 32'h40A00000);
        step(1'b1, 1'b0, 1'b1, 32'h3F000000, 32'h3F800000);
        chk("b2b_single_c", c, 32'h40800000);
        idle();
        idle();
        chk("b2b_third_c", c, 32'h40600000);
        chk("b2b_third_ov", {31'd0, output_valid}, 32'd1);

        // Reset in the middle of a vector, then accumulate without start
        step(1'b1, 1'b1, 1'b0, 32'h40400000, 32'h40400000);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midreset_c", c, 32'd0);
        chk("midreset_ov", {31'd0, output_valid}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b1, 32'h40000000, 32'h40400000);
        idle();
        idle();
        chk("nostart_c", c, 32'h40C00000);
        chk("nostart_ov", {31'd0, output_valid}, 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            rs = 1'($urandom);
            rl = 1'($urandom);
            if (rv) begin
                rs     = in_vec ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 7) != 0);
                rl     = ($urandom_range(0, 2) == 0);
                in_vec = !rl;
            end
            step(rv, rs, rl, rnd_op(), rnd_op());
        end
        for (int n = 0; n < 4; n++) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
